// File: rtl/frog_game_ctrl.sv
// Frog game supervisor: per-frame collision/goal evaluation driving lives, score
// and a PLAY/HIT/WIN/OVER state machine with a frame-count hold after each event.
module frog_game_ctrl #(
   parameter int LIVES       = 3,
   parameter int GOAL_Y      = 20,
   parameter int HOLD_FRAMES = 60
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_animate,
   input  logic        i_start,
   input  logic [11:0] i_frog_x1,
   input  logic [11:0] i_frog_x2,
   input  logic [11:0] i_frog_y1,
   input  logic [11:0] i_frog_y2,
   input  logic [35:0] i_obs_x1,
   input  logic [35:0] i_obs_x2,
   input  logic [35:0] i_obs_y1,
   input  logic [35:0] i_obs_y2,
   output logic [2:0]  o_collide,
   output logic [3:0]  o_lives,
   output logic [7:0]  o_score,
   output logic [1:0]  o_state,
   output logic        o_frog_rst
);

   typedef enum logic [1:0] {
      ST_PLAY = 2'd0,
      ST_HIT  = 2'd1,
      ST_WIN  = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   localparam logic [3:0]  LIVES_L  = 4'(LIVES);
   localparam logic [11:0] GOAL_Y_L = 12'(GOAL_Y);
   localparam logic [7:0]  HOLD_L   = 8'(HOLD_FRAMES);

   state_t      state_reg;
   logic [7:0]  hold_reg;
   logic [2:0]  overlap;
   logic        goal_hit;

   // Strict inequalities: boxes that merely touch along an edge do not collide.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_overlap
         assign overlap[gi] = (i_frog_x1 < i_obs_x2[12*gi +: 12]) &&
                              (i_obs_x1[12*gi +: 12] < i_frog_x2) &&
                              (i_frog_y1 < i_obs_y2[12*gi +: 12]) &&
                              (i_obs_y1[12*gi +: 12] < i_frog_y2);
      end
   endgenerate

   assign goal_hit = (i_frog_y1 <= GOAL_Y_L);
   assign o_state  = state_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg  <= ST_PLAY;
         hold_reg   <= 8'd0;
         o_lives    <= LIVES_L;
         o_score    <= 8'd0;
         o_collide  <= 3'b000;
         o_frog_rst <= 1'b0;
      end else begin
         o_frog_rst <= 1'b0;
         if (i_animate) begin
            o_collide <= overlap;
         end

         // Restart is the only transition that does not wait for a frame strobe.
         if (state_reg == ST_OVER) begin
            if (i_start) begin
               state_reg  <= ST_PLAY;
               o_lives    <= LIVES_L;
               o_score    <= 8'd0;
               o_frog_rst <= 1'b1;
            end
         end else if (i_animate) begin
            case (state_reg)
               ST_PLAY: begin
                  if (|overlap) begin
                     o_lives <= o_lives - 4'd1;
                     if (o_lives == 4'd1) begin
                        state_reg <= ST_OVER;
                     end else begin
                        state_reg <= ST_HIT;
                        hold_reg  <= HOLD_L;
                     end
                  end else if (goal_hit) begin
                     if (o_score != 8'hFF) begin
                        o_score <= o_score + 8'd1;
                     end
                     state_reg <= ST_WIN;
                     hold_reg  <= HOLD_L;
                  end
               end
               ST_HIT, ST_WIN: begin
                  if (hold_reg <= 8'd1) begin
                     state_reg  <= ST_PLAY;
                     hold_reg   <= 8'd0;
                     o_frog_rst <= 1'b1;
                  end else begin
                     hold_reg <= hold_reg - 8'd1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Bench for frog_game_ctrl: directed scenarios plus a randomized run checked
// against a frame-level behavioural model of the game rules.
module tb_frog_game_ctrl;

   localparam int LIVES  = 3;
   localparam int GOAL_Y = 20;
   localparam int HOLD   = 3;

   logic        clk = 1'b0;
   logic        rst, animate, start;
   logic [11:0] fx1, fx2, fy1, fy2;
   logic [35:0] ox1, ox2, oy1, oy2;
   logic [2:0]  collide;
   logic [3:0]  lives;
   logic [7:0]  score;
   logic [1:0]  state;
   logic        frog_rst;

   int checks = 0;
   int errors = 0;

   // Reference model of the game, advanced once per clock edge.
   int m_state, m_lives, m_score, m_hold, m_collide, m_frst;

   always #5 clk = ~clk;

   frog_game_ctrl #(.LIVES(LIVES), .GOAL_Y(GOAL_Y), .HOLD_FRAMES(HOLD)) dut (
      .i_clk(clk), .i_rst(rst), .i_animate(animate), .i_start(start),
      .i_frog_x1(fx1), .i_frog_x2(fx2), .i_frog_y1(fy1), .i_frog_y2(fy2),
      .i_obs_x1(ox1), .i_obs_x2(ox2), .i_obs_y1(oy1), .i_obs_y2(oy2),
      .o_collide(collide), .o_lives(lives), .o_score(score), .o_state(state),
      .o_frog_rst(frog_rst)
   );

   function automatic int model_overlap();
      int v, ax1, ax2, ay1, ay2, bx1, bx2, by1, by2;
      v   = 0;
      ax1 = int'(fx1); ax2 = int'(fx2); ay1 = int'(fy1); ay2 = int'(fy2);
      for (int k = 0; k < 3; k++) begin
         bx1 = int'((ox1 >> (12*k)) & 36'hFFF);
         bx2 = int'((ox2 >> (12*k)) & 36'hFFF);
         by1 = int'((oy1 >> (12*k)) & 36'hFFF);
         by2 = int'((oy2 >> (12*k)) & 36'hFFF);
         if (ax1 < bx2 && bx1 < ax2 && ay1 < by2 && by1 < ay2) v += (1 << k);
      end
      return v;
   endfunction

   task automatic model_step();
      int ov;
      ov = model_overlap();
      if (rst) begin
         m_state = 0; m_lives = LIVES; m_score = 0; m_hold = 0; m_collide = 0; m_frst = 0;
      end else begin
         m_frst = 0;
         if (animate) m_collide = ov;
         if (m_state == 3) begin
            if (start) begin
               m_state = 0; m_lives = LIVES; m_score = 0; m_frst = 1;
            end
         end else if (animate) begin
            if (m_state == 0) begin
               if (ov != 0) begin
                  m_lives = m_lives - 1;
                  if (m_lives == 0) m_state = 3;
                  else begin m_state = 1; m_hold = HOLD; end
               end else if (int'(fy1) <= GOAL_Y) begin
                  m_score = (m_score < 255) ? m_score + 1 : 255;
                  m_state = 2;
                  m_hold  = HOLD;
               end
            end else begin
               m_hold = m_hold - 1;
               if (m_hold == 0) begin m_state = 0; m_frst = 1; end
            end
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Gap cycle, then one animate cycle; outputs afterwards reflect that frame.
   task automatic pulse();
      step();
      animate = 1'b1;
      step();
      animate = 1'b0;
      $display("frame: state=%0d lives=%0d score=%0d collide=%b frog_rst=%b",
               state, lives, score, collide, frog_rst);
   endtask

   task automatic release_hold();
      repeat (HOLD) pulse();
   endtask

   task automatic set_frog(input int x1, input int y1, input int x2, input int y2);
      fx1 = 12'(x1); fy1 = 12'(y1); fx2 = 12'(x2); fy2 = 12'(y2);
   endtask

   task automatic set_obs(input int k, input int x1, input int y1, input int x2, input int y2);
      ox1[12*k +: 12] = 12'(x1); oy1[12*k +: 12] = 12'(y1);
      ox2[12*k +: 12] = 12'(x2); oy2[12*k +: 12] = 12'(y2);
   endtask

   task automatic clear_obs();
      ox1 = '0; ox2 = '0; oy1 = '0; oy2 = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
      checks++; if (lives !== 4'd3) begin errors++; $display("FAIL reset_lives got %0d want 3", lives); end
      checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
      checks++; if (collide !== 3'b000) begin errors++; $display("FAIL reset_collide got %b want 000", collide); end
      step();
      checks++; if (frog_rst !== 1'b0) begin errors++; $display("FAIL reset_no_frog_rst got %b want 0", frog_rst); end
   endtask

   task automatic test_collision();
      clear_obs();
      set_frog(300, 450, 340, 480);
      set_obs(1, 310, 460, 330, 470);
      pulse();
      checks++; if (collide !== 3'b010) begin errors++; $display("FAIL hit_collide got %b want 010", collide); end
      checks++; if (lives !== 4'd2) begin errors++; $display("FAIL hit_lives got %0d want 2", lives); end
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL hit_state got %0d want 1", state); end
   endtask

   task automatic test_hold_release();
      int nrst;
      nrst = 0;
      for (int i = 1; i <= HOLD; i++) begin
         pulse();
         if (frog_rst === 1'b1) nrst++;
         checks++; if (lives !== 4'd2) begin errors++; $display("FAIL hold_lives pulse %0d got %0d want 2", i, lives); end
         if (i < HOLD) begin
            checks++; if (state !== 2'd1) begin errors++; $display("FAIL hold_state pulse %0d got %0d want 1", i, state); end
         end else begin
            checks++; if (frog_rst !== 1'b1) begin errors++; $display("FAIL hold_frog_rst got %b want 1", frog_rst); end
            checks++; if (state !== 2'd0) begin errors++; $display("FAIL hold_release_state got %0d want 0", state); end
         end
      end
      step();
      if (frog_rst === 1'b1) nrst++;
      checks++; if (nrst != 1) begin errors++; $display("FAIL hold_frog_rst_count got %0d want 1", nrst); end
      clear_obs();
   endtask

   task automatic test_goal();
      clear_obs();
      set_frog(300, 20, 340, 50);
      pulse();
      checks++; if (score !== 8'd1) begin errors++; $display("FAIL goal_score got %0d want 1", score); end
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL goal_state got %0d want 2", state); end
      release_hold();
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL goal_release got %0d want 0", state); end
      set_obs(0, 310, 30, 330, 40);
      pulse();
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL goal_hit_state got %0d want 1", state); end
      checks++; if (score !== 8'd1) begin errors++; $display("FAIL goal_hit_score got %0d want 1", score); end
      checks++; if (collide !== 3'b001) begin errors++; $display("FAIL goal_hit_collide got %b want 001", collide); end
      release_hold();
      checks++; if (lives !== 4'd1) begin errors++; $display("FAIL goal_hold_lives got %0d want 1", lives); end
      clear_obs();
   endtask

   task automatic test_game_over();
      do_reset();
      clear_obs();
      set_frog(300, 20, 340, 50);
      pulse();
      release_hold();
      set_frog(300, 450, 340, 480);
      set_obs(1, 310, 460, 330, 470);
      for (int i = 0; i < 3; i++) begin
         pulse();
         if (i < 2) release_hold();
      end
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL over_state got %0d want 3", state); end
      checks++; if (lives !== 4'd0) begin errors++; $display("FAIL over_lives got %0d want 0", lives); end
      set_frog(300, 20, 340, 50);
      clear_obs();
      repeat (4) pulse();
      checks++; if (state !== 2'd3 || lives !== 4'd0 || score !== 8'd1) begin
         errors++; $display("FAIL over_frozen got state=%0d lives=%0d score=%0d want 3/0/1", state, lives, score);
      end
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (lives !== 4'd3) begin errors++; $display("FAIL restart_lives got %0d want 3", lives); end
      checks++; if (score !== 8'd0) begin errors++; $display("FAIL restart_score got %0d want 0", score); end
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL restart_state got %0d want 0", state); end
      checks++; if (frog_rst !== 1'b1) begin errors++; $display("FAIL restart_frog_rst got %b want 1", frog_rst); end
      step();
      checks++; if (frog_rst !== 1'b0) begin errors++; $display("FAIL restart_frog_rst_len got %b want 0", frog_rst); end
      // i_start in PLAY must do nothing.
      set_frog(300, 450, 340, 480);
      start = 1'b1;
      pulse();
      start = 1'b0;
      checks++; if (state !== 2'd0 || frog_rst !== 1'b0) begin
         errors++; $display("FAIL start_in_play got state=%0d frog_rst=%b want 0/0", state, frog_rst);
      end
   endtask

   task automatic test_score_saturate();
      do_reset();
      clear_obs();
      set_frog(300, 10, 340, 40);
      for (int g = 1; g <= 256; g++) begin
         pulse();
         if (g == 255) begin
            checks++; if (score !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d want 255", score); end
         end
         release_hold();
      end
      checks++; if (score !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", score); end
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL sat_state got %0d want 0", state); end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      clear_obs();
      set_frog(300, 20, 340, 50);
      pulse();
      release_hold();
      set_frog(300, 450, 340, 480);
      set_obs(2, 310, 460, 330, 470);
      pulse();
      pulse();
      step();
      rst = 1'b1;
      animate = 1'b1;
      step();
      rst = 1'b0;
      animate = 1'b0;
      checks++; if (state !== 2'd0 || lives !== 4'd3 || score !== 8'd0 || collide !== 3'b000 || frog_rst !== 1'b0) begin
         errors++; $display("FAIL midhold_reset got state=%0d lives=%0d score=%0d collide=%b frog_rst=%b want 0/3/0/000/0",
                            state, lives, score, collide, frog_rst);
      end
      step();
      checks++; if (frog_rst !== 1'b0) begin errors++; $display("FAIL midhold_no_frog_rst got %b want 0", frog_rst); end
      clear_obs();
   endtask

   task automatic test_random();
      int x, y;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         rst     = ($urandom_range(0, 199) == 0);
         animate = ($urandom_range(0, 1) == 1);
         start   = ($urandom_range(0, 7) == 0);
         x = $urandom_range(0, 60); y = $urandom_range(0, 60);
         set_frog(x, y, x + $urandom_range(0, 20), y + $urandom_range(0, 20));
         for (int k = 0; k < 3; k++) begin
            x = $urandom_range(0, 80); y = $urandom_range(0, 80);
            set_obs(k, x, y, x + $urandom_range(0, 12), y + $urandom_range(0, 12));
         end
         step();
         if (animate || start || rst)
            $display("rand %0d: rst=%b anim=%b start=%b state=%0d lives=%0d score=%0d collide=%b frog_rst=%b",
                     c, rst, animate, start, state, lives, score, collide, frog_rst);
         checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rand_state cycle %0d got %0d want %0d", c, state, m_state); end
         checks++; if (lives !== 4'(m_lives)) begin errors++; $display("FAIL rand_lives cycle %0d got %0d want %0d", c, lives, m_lives); end
         checks++; if (score !== 8'(m_score)) begin errors++; $display("FAIL rand_score cycle %0d got %0d want %0d", c, score, m_score); end
         checks++; if (collide !== 3'(m_collide)) begin errors++; $display("FAIL rand_collide cycle %0d got %b want %0d", c, collide, m_collide); end
         checks++; if (frog_rst !== 1'(m_frst)) begin errors++; $display("FAIL rand_frog_rst cycle %0d got %b want %0d", c, frog_rst, m_frst); end
      end
      rst = 1'b0; animate = 1'b0; start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; animate = 1'b0; start = 1'b0;
      fx1 = '0; fx2 = '0; fy1 = '0; fy2 = '0;
      ox1 = '0; ox2 = '0; oy1 = '0; oy2 = '0;
      m_state = 0; m_lives = LIVES; m_score = 0; m_hold = 0; m_collide = 0; m_frst = 0;
      test_reset();
      test_collision();
      test_hold_release();
      test_goal();
      test_game_over();
      test_score_saturate();
      test_reset_mid_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
